// File: rtl/mcu_block_tiler.sv
// mcu_block_tiler: raster-to-8x8-block reorder buffer for a DCT/JPEG coder.
//   Pixels arrive line by line (NCH channels of DW bits). 8-line bands are
//   collected in two ping-pong banks; a full bank is drained as 8-sample
//   block rows, one channel at a time, in interleaved (ORDER=0) or planar
//   (ORDER=1) block order.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     pixel stream, channel c at [c*DW +: DW]
//   in_sof                        marks the first pixel of a frame
//   out_valid/out_ready/out_data  block-row stream, sample k at [k*DW +: DW]
//   out_ch, out_row               channel and row (0..7) of the current row
//   out_sob, out_eof              first row of a block / last row of frame
//   sync_err                      one-cycle pulse on a misplaced in_sof
module mcu_block_tiler #(
  parameter  int WIDTH  = 1280,
  parameter  int HEIGHT = 720,
  parameter  int NCH    = 3,
  parameter  int DW     = 8,
  parameter  int ORDER  = 0,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*DW-1:0]   out_data,
  output logic [CW-1:0]     out_ch,
  output logic [2:0]        out_row,
  output logic              out_sob,
  output logic              out_eof,
  output logic              sync_err
);

  localparam int PW    = NCH * DW;
  localparam int NBX   = WIDTH / 8;
  localparam int NBAND = HEIGHT / 8;
  localparam int DEPTH = 2 * WIDTH;          // 2 banks x 8 lines x NBX words
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = $clog2(WIDTH);
  localparam int BXW   = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BNW   = (NBAND > 1) ? $clog2(NBAND) : 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;
  typedef enum logic [1:0] {IDLE, READ, HOLD} drain_st_e;

  // One RAM per lane (x mod 8) so a whole block row of 8 pixels is read
  // in one access, while a single pixel is written per cycle.
  logic [PW-1:0] mem [8][DEPTH];
  logic [PW-1:0] rd_word [8];

  bank_st_e        bank_st [2];
  logic            bank_last [2];   // bank holds the final band of a frame
  logic            wr_bank, rd_bank, run;
  logic [XW-1:0]   x, x_eff;
  logic [2:0]      y, y_eff;
  logic [BNW-1:0]  band, band_eff;
  logic            accept, sof_err, band_done;
  logic [AW-1:0]   wr_addr, rd_addr;

  drain_st_e       state, state_nxt;
  logic            issue, release_bank, issue_bank, out_last, last_issue;
  logic [2:0]      row;
  logic [CW-1:0]   ch;
  logic [BXW-1:0]  bx;

  // ---------------------------------------------------------------- fill side
  // run holds in_ready low until the first edge after reset.
  assign in_ready = run && (bank_st[wr_bank] != FULL);
  assign accept   = in_valid && in_ready;
  assign sof_err  = accept && in_sof && (x != '0 || y != '0 || band != '0);

  // A misplaced frame start restarts the band: the pixel lands at (0,0).
  assign x_eff     = sof_err ? '0 : x;
  assign y_eff     = sof_err ? '0 : y;
  assign band_eff  = sof_err ? '0 : band;
  assign band_done = (x_eff == XW'(WIDTH - 1)) && (y_eff == 3'd7);
  assign wr_addr   = AW'(int'(wr_bank) * WIDTH + int'(y_eff) * NBX + int'(x_eff >> 3));

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      x        <= '0;
      y        <= '0;
      band     <= '0;
      sync_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        bank_st[i]   <= EMPTY;
        bank_last[i] <= 1'b0;
      end
    end else begin
      run      <= 1'b1;
      sync_err <= sof_err;
      if (accept) begin
        if (x_eff == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= y_eff + 3'd1;
        end else begin
          x <= x_eff + 1'b1;
          y <= y_eff;
        end
        if (band_done) begin
          bank_st[wr_bank]   <= FULL;
          bank_last[wr_bank] <= (band_eff == BNW'(NBAND - 1));
          wr_bank            <= ~wr_bank;
          band               <= (band_eff == BNW'(NBAND - 1)) ? '0 : band_eff + 1'b1;
        end else begin
          // Also discards a partly filled band after a sync error.
          bank_st[wr_bank] <= FILLING;
          band             <= band_eff;
        end
      end
      // The released bank is FULL, the written one is not: never the same bank.
      if (release_bank) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= ~rd_bank;
      end
    end
  end

  // NOTE: the pixel RAM has no reset; bank states alone decide validity, and
  // leaving it unreset lets synthesis map it onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[x_eff[2:0]][wr_addr] <= in_data;
  end

  // --------------------------------------------------------------- drain side
  assign last_issue = (row == 3'd7) && (ch == CW'(NCH - 1)) && (bx == BXW'(NBX - 1));
  assign rd_addr    = AW'(int'(issue_bank) * WIDTH + int'(row) * NBX + int'(bx));
  assign out_valid  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    release_bank = 1'b0;
    issue_bank   = rd_bank;
    case (state)
      IDLE: begin
        if (bank_st[rd_bank] == FULL) begin
          issue     = 1'b1;
          state_nxt = READ;
        end
      end
      READ, HOLD: begin
        if (!out_ready) begin
          state_nxt = HOLD;
        end else if (!out_last) begin
          issue     = 1'b1;
          state_nxt = READ;
        end else begin
          // Bank done: continue straight into the other bank if it is ready.
          release_bank = 1'b1;
          issue_bank   = ~rd_bank;
          if (bank_st[~rd_bank] == FULL) begin
            issue     = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters hold the next row to issue; sidebands are captured with the read
  // so they stay aligned with (and as stable as) the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row      <= '0;
      ch       <= '0;
      bx       <= '0;
      out_ch   <= '0;
      out_row  <= '0;
      out_sob  <= 1'b0;
      out_eof  <= 1'b0;
      out_last <= 1'b0;
      for (int k = 0; k < 8; k++) rd_word[k] <= '0;
    end else if (issue) begin
      for (int k = 0; k < 8; k++) rd_word[k] <= mem[k][rd_addr];
      out_ch   <= ch;
      out_row  <= row;
      out_sob  <= (row == 3'd0);
      out_eof  <= last_issue && bank_last[issue_bank];
      out_last <= last_issue;
      row      <= row + 3'd1;
      if (row == 3'd7) begin
        if (ORDER == 0) begin
          if (ch == CW'(NCH - 1)) begin
            ch <= '0;
            bx <= (bx == BXW'(NBX - 1)) ? '0 : bx + 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end else begin
          if (bx == BXW'(NBX - 1)) begin
            bx <= '0;
            ch <= (ch == CW'(NCH - 1)) ? '0 : ch + 1'b1;
          end else begin
            bx <= bx + 1'b1;
          end
        end
      end
    end
  end

  // Channel select after the RAM register.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < 8; k++) out_data[k*DW +: DW] = rd_word[k][int'(out_ch)*DW +: DW];
  end

endmodule
